edge_event_arb: RTL and testbench

Multi-channel edge-event scheduler. Samples N single-bit event lines, detects edges on each, and latches them as pending requests. A round-robin arbiter then serialises the requests onto one valid/ready event port, one channel index per transaction. It sits between status/strobe sources (buttons, sensor flags, peripheral done lines) and a single downstream consumer such as an interrupt or event FIFO.

---
 rtl/edge_event_arb.sv | 97 +++++++++
 tb/tb_edge_event_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arb.sv
// edge_event_arb: N-channel edge detector feeding sticky pending bits, served
// round-robin onto one registered valid/ready port. EDGE_EVENT_ARB_ANY_EDGE_EN selects both-edge detection.
module edge_event_arb #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [N-1:0]  data_i,
  output logic          evt_valid_o,
  output logic [IW-1:0] evt_id_o,
  input  logic          evt_ready_i,
  output logic [N-1:0]  ovf_o,
  input  logic          ovf_clr_i,
  output logic [N-1:0]  pend_o
);

  // Handshake: a transfer happens on a rising clk edge where evt_valid_o && evt_ready_i;
  // once raised, valid and id hold stable until that transfer occurs.

  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_pend;
  logic [N-1:0]  r_ovf;
  logic          r_valid;
  logic [IW-1:0] r_id;
  logic [IW-1:0] r_ptr;

  logic [N-1:0]  w_edge;
  logic          w_xfer;
  logic [N-1:0]  w_served;
  logic [N-1:0]  w_eff;
  logic [N-1:0]  w_ovf_set;
  logic          w_load;
  logic          w_found;
  logic [IW-1:0] w_cand;

`ifdef EDGE_EVENT_ARB_ANY_EDGE_EN
  assign w_edge = r_a ^ r_b;
`else
  assign w_edge = r_a & ~r_b;
`endif

  assign w_xfer    = r_valid & evt_ready_i;
  assign w_served  = w_xfer ? (N'(1) << r_id) : '0;
  assign w_eff     = r_pend & ~w_served;
  assign w_ovf_set = w_edge & r_pend & ~w_served;
  assign w_load    = ~r_valid | w_xfer;

  // Circular first-set search starting just after the last grant.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(r_ptr) + k) % N;
      if (!w_found && w_eff[idx]) begin
        w_found = 1'b1;
        w_cand  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_a    <= '0;
      r_b    <= '0;
      r_pend <= '0;
      r_ovf  <= '0;
    end else begin
      r_a    <= data_i;
      r_b    <= r_a;
      r_pend <= w_eff | w_edge;
      r_ovf  <= (ovf_clr_i ? '0 : r_ovf) | w_ovf_set;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_ptr   <= IW'(N - 1);
    end else if (w_load) begin
      r_valid <= w_found;
      r_id    <= w_cand;
      if (w_found) begin
        r_ptr <= w_cand;
      end
    end
  end

  assign evt_valid_o = r_valid;
  assign evt_id_o    = r_id;
  assign ovf_o       = r_ovf;
  assign pend_o      = r_pend;

endmodule

// File: tb/tb_edge_event_arb.sv
// Bench for edge_event_arb: directed scenarios plus random traffic, all checked
// cycle by cycle against a rule-level model and an expected-id queue.
module tb_edge_event_arb;
  localparam int N = 4;
  localparam int IW = $clog2(N);
`ifdef EDGE_EVENT_ARB_ANY_EDGE_EN
  localparam logic EXP_ANY = 1'b1;
`else
  localparam logic EXP_ANY = 1'b0;
`endif

  logic          clk;
  logic          rst_n_i;
  logic [N-1:0]  data_i;
  logic          evt_valid_o;
  logic [IW-1:0] evt_id_o;
  logic          evt_ready_i;
  logic [N-1:0]  ovf_o;
  logic          ovf_clr_i;
  logic [N-1:0]  pend_o;

  edge_event_arb #(.N(N)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .data_i(data_i),
    .evt_valid_o(evt_valid_o), .evt_id_o(evt_id_o), .evt_ready_i(evt_ready_i),
    .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i), .pend_o(pend_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [IW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Directed expectations written for rising-edge-only detection.
  task automatic dchk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
`ifndef EDGE_EVENT_ARB_ANY_EDGE_EN
    check(tag, obs, exp);
`endif
  endtask

  // reference model: history of the last two samples of each line plus the
  // pending/overflow sets and the offered event
  int m_hist1[N];
  int m_hist2[N];
  int m_pend[N];
  int m_ovf[N];
  int m_ptr;
  int m_valid;
  int m_id;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_hist1[i] = 0; m_hist2[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
    end
    m_ptr = N - 1; m_valid = 0; m_id = 0;
  endfunction

  function automatic logic [N-1:0] pack(input int v[N]);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (v[i] != 0);
    return r;
  endfunction

  function automatic void m_step(input logic [N-1:0] d, input logic rdy, input logic clr);
    int ev, served, xfer, cand;
    int eff[N];
    xfer = (m_valid != 0 && rdy) ? 1 : 0;
    if (xfer != 0) exp_q.push_back(IW'(m_id));
    for (int i = 0; i < N; i++) begin
      if (EXP_ANY) ev = (m_hist1[i] != m_hist2[i]) ? 1 : 0;
      else         ev = (m_hist1[i] == 1 && m_hist2[i] == 0) ? 1 : 0;
      served = (xfer != 0 && m_id == i) ? 1 : 0;
      eff[i] = (m_pend[i] != 0 && served == 0) ? 1 : 0;
      if (ev != 0 && eff[i] != 0) m_ovf[i] = 1;
      else if (clr) m_ovf[i] = 0;
      m_pend[i] = (ev != 0 || eff[i] != 0) ? 1 : 0;
    end
    if (m_valid == 0 || xfer != 0) begin
      cand = -1;
      for (int k = 1; k <= N; k++)
        if (cand < 0 && eff[(m_ptr + k) % N] != 0) cand = (m_ptr + k) % N;
      m_valid = (cand >= 0) ? 1 : 0;
      m_id = (cand >= 0) ? cand : 0;
      if (cand >= 0) m_ptr = cand;
    end
    for (int i = 0; i < N; i++) begin
      m_hist2[i] = m_hist1[i];
      m_hist1[i] = int'(d[i]);
    end
  endfunction

  // driver: apply inputs at the falling edge, advance one cycle, compare
  task automatic tick(input logic [N-1:0] d, input logic rdy, input logic clr);
    logic          dut_x;
    logic [IW-1:0] dut_id;
    logic [IW-1:0] exp_id;
    data_i = d; evt_ready_i = rdy; ovf_clr_i = clr;
    dut_x = evt_valid_o && rdy;
    dut_id = evt_id_o;
    @(posedge clk);
    m_step(d, rdy, clr);
    if (dut_x) begin
      if (exp_q.size() == 0) check("sb_unexpected_xfer", 32'(dut_id), 32'hffff_ffff);
      else begin
        exp_id = exp_q.pop_front();
        check("sb_id", 32'(dut_id), 32'(exp_id));
      end
    end
    @(negedge clk);
    check("m_valid", 32'(evt_valid_o), 32'(m_valid));
    check("m_id", 32'(evt_id_o), 32'(m_id));
    check("m_pend", 32'(pend_o), 32'(pack(m_pend)));
    check("m_ovf", 32'(ovf_o), 32'(pack(m_ovf)));
  endtask

  initial begin
    logic saw3;
    rst_n_i = 1'b0; data_i = '0; evt_ready_i = 1'b0; ovf_clr_i = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(evt_valid_o), 0);
    check("rst_id", 32'(evt_id_o), 0);
    check("rst_pend", 32'(pend_o), 0);
    check("rst_ovf", 32'(ovf_o), 0);
    rst_n_i = 1'b1;

    // reset priority: all four channels at once come out 0,1,2,3
    tick(4'b0000, 1, 0);
    tick(4'b1111, 1, 0);
    tick(4'b0000, 1, 0);
    dchk("t1_pend", 32'(pend_o), 32'hf);
    dchk("t1_early", 32'(evt_valid_o), 0);
    for (int j = 0; j < 4; j++) begin
      tick(4'b0000, 1, 0);
      dchk("t1_valid", 32'(evt_valid_o), 1);
      dchk("t1_id", 32'(evt_id_o), 32'(j));
    end
    tick(4'b0000, 1, 0);
    dchk("t1_idle", 32'(evt_valid_o), 0);
    dchk("t1_ovf", 32'(ovf_o), 0);
    repeat (3) tick(4'b0000, 1, 0);

    // stall hold, then release gives 2 then 1
    tick(4'b0100, 0, 0);
    tick(4'b0110, 0, 0);
    for (int j = 0; j < 10; j++) begin
      tick(4'b0110, 0, 0);
      dchk("t2_hold_v", 32'(evt_valid_o), 1);
      dchk("t2_hold_id", 32'(evt_id_o), 2);
    end
    tick(4'b0110, 1, 0);
    dchk("t2_next_id", 32'(evt_id_o), 1);
    tick(4'b0000, 1, 0);
    dchk("t2_drain", 32'(evt_valid_o), 0);

    // round robin from ptr=1: 3 before 0
    repeat (2) tick(4'b0000, 1, 0);
    tick(4'b1001, 1, 0);
    tick(4'b0000, 1, 0);
    tick(4'b0000, 1, 0);
    dchk("t3_first", 32'(evt_id_o), 3);
    tick(4'b0000, 1, 0);
    dchk("t3_second", 32'(evt_id_o), 0);
    tick(4'b0000, 1, 0);
    dchk("t3_drain", 32'(evt_valid_o), 0);

    // overflow on channel 1
    repeat (2) tick(4'b0000, 0, 0);
    tick(4'b0010, 0, 0);
    tick(4'b0000, 0, 0);
    tick(4'b0010, 0, 0);
    tick(4'b0010, 0, 0);
    dchk("t4_ovf", 32'(ovf_o), 32'h2);
    tick(4'b0010, 1, 0);
    dchk("t4_one_evt", 32'(evt_valid_o), 0);
    tick(4'b0000, 0, 1);
    dchk("t4_clr", 32'(ovf_o), 0);
    tick(4'b0010, 0, 0);
    tick(4'b0000, 0, 0);
    tick(4'b0010, 0, 0);
    tick(4'b0000, 0, 1);
    dchk("t4_set_wins", 32'(ovf_o), 32'h2);
    tick(4'b0000, 0, 1);
    dchk("t4_lone_clr", 32'(ovf_o), 0);
    repeat (3) tick(4'b0000, 1, 0);

    // same-cycle re-arm on channel 0
    tick(4'b0001, 1, 0);
    tick(4'b0000, 1, 0);
    tick(4'b0001, 1, 0);
    dchk("t5_offer", 32'(evt_valid_o), 1);
    tick(4'b0001, 1, 0);
    dchk("t5_pend0", 32'(pend_o[0]), 1);
    dchk("t5_no_ovf", 32'(ovf_o), 0);
    tick(4'b0001, 1, 0);
    dchk("t5_again_v", 32'(evt_valid_o), 1);
    dchk("t5_again_id", 32'(evt_id_o), 0);
    repeat (3) tick(4'b0000, 1, 0);

    // falling edge on channel 3 counts only with both-edge detection
    repeat (6) tick(4'b1000, 1, 0);
    saw3 = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick(4'b0000, 1, 0);
      if (evt_valid_o && evt_id_o == 2'd3) saw3 = 1'b1;
    end
    check("t6_fall_evt", 32'(saw3), 32'(EXP_ANY));

    // asynchronous reset mid-stall
    repeat (4) tick(4'b0100, 0, 0);
    check("t6_stalled", 32'(evt_valid_o), 1);
    #2 rst_n_i = 1'b0;
    #1;
    check("t6_arst_valid", 32'(evt_valid_o), 0);
    check("t6_arst_id", 32'(evt_id_o), 0);
    check("t6_arst_pend", 32'(pend_o), 0);
    check("t6_arst_ovf", 32'(ovf_o), 0);
    m_reset();
    exp_q.delete();
    data_i = '0;
    @(negedge clk);
    rst_n_i = 1'b1;

    // random traffic
    for (int j = 0; j < 600; j++) begin
      tick(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0));
    end
    repeat (10) tick(4'b0000, 1, 0);
    check("sb_drain", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
